// File: rtl/dbus_lsu.sv
// Load/store unit for one core slot of the shared dmem bus: size/alignment checks, sub-word lanes, LR/SC.
// Define DBUS_LSU_AMO_EN to add AMOSWAP/AMOADD, executed as an LR/SC retry loop.
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 16
`endif

module dbus_lsu #(
  parameter int DMEM_ADDRW = `DMEM_ADDRW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  re_o,
  output logic                  we_o,
  output logic [DMEM_ADDRW-1:0] addr_o,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  is_lr_o,
  output logic                  is_sc_o,
  input  logic [31:0]           rdata_i,
  input  logic                  stall_i
);

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_STORE   = 3'b001;
  localparam logic [2:0] OP_LR      = 3'b010;
  localparam logic [2:0] OP_SC      = 3'b011;
  localparam logic [2:0] OP_AMOSWAP = 3'b100;
  localparam logic [2:0] OP_AMOADD  = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, ERR
`ifdef DBUS_LSU_AMO_EN
    , AMO_SC, AMO_SCW
`endif
  } state_t;

  state_t                state;
  logic [2:0]            op_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DMEM_ADDRW+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  amo_q;

`ifdef DBUS_LSU_AMO_EN
  logic [31:0] old_q;
  assign amo_q = (op_q == OP_AMOSWAP) || (op_q == OP_AMOADD);
`else
  assign amo_q = 1'b0;
`endif

  function automatic logic req_bad(input logic [2:0] op, input logic [1:0] size,
                                   input logic [1:0] off);
    logic bad;
    bad = (size == 2'b11) || (op[2:1] == 2'b11);
`ifndef DBUS_LSU_AMO_EN
    bad = bad || (op == OP_AMOSWAP) || (op == OP_AMOADD);
`endif
    bad = bad || ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    bad = bad || ((op != OP_LOAD) && (op != OP_STORE) && (size != SZ_WORD));
    return bad;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input logic [31:0] rd, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
    logic [31:0] s;
    s = rd >> {off, 3'b000};
    case (size)
      SZ_BYTE: return {{24{~uns & s[7]}}, s[7:0]};
      SZ_HALF: return {{16{~uns & s[15]}}, s[15:0]};
      default: return rd;
    endcase
  endfunction

  // Bus outputs and ready are registered for the state being entered, so they hold steady through stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      re_o        <= 1'b0;
      we_o        <= 1'b0;
      is_lr_o     <= 1'b0;
      is_sc_o     <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      wstrb_o     <= '0;
      op_q        <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef DBUS_LSU_AMO_EN
      old_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            op_q        <= req_op_i;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            addr_q      <= req_addr_i[DMEM_ADDRW+1:0];
            wdata_q     <= req_wdata_i;
            req_ready_o <= 1'b0;
            if (req_bad(req_op_i, req_size_i, req_addr_i[1:0])) begin
              state <= ERR;
            end else begin
              state   <= ISSUE;
              addr_o  <= req_addr_i[DMEM_ADDRW+1:2];
              re_o    <= (req_op_i != OP_STORE) && (req_op_i != OP_SC);
              we_o    <= (req_op_i == OP_STORE) || (req_op_i == OP_SC);
              is_lr_o <= (req_op_i == OP_LR) || req_op_i[2];
              is_sc_o <= (req_op_i == OP_SC);
              if ((req_op_i == OP_STORE) || (req_op_i == OP_SC)) begin
                wdata_o <= lane_data(req_size_i, req_wdata_i);
                wstrb_o <= lane_strb(req_size_i, req_addr_i[1:0]);
              end
            end
          end
        end
        ISSUE: begin
          if (!stall_i) begin
            state   <= WAIT;
            re_o    <= 1'b0;
            we_o    <= 1'b0;
            is_lr_o <= 1'b0;
            is_sc_o <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
            wstrb_o <= '0;
          end
        end
        WAIT: begin
`ifdef DBUS_LSU_AMO_EN
          if (amo_q) begin
            state   <= AMO_SC;
            old_q   <= rdata_i;
            we_o    <= 1'b1;
            is_sc_o <= 1'b1;
            addr_o  <= addr_q[DMEM_ADDRW+1:2];
            wstrb_o <= 4'b1111;
            wdata_o <= (op_q == OP_AMOADD) ? rdata_i + wdata_q : wdata_q;
          end else begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
          end
`else
          state       <= IDLE;
          req_ready_o <= 1'b1;
`endif
        end
        ERR: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
`ifdef DBUS_LSU_AMO_EN
        AMO_SC: begin
          if (!stall_i) begin
            state   <= AMO_SCW;
            we_o    <= 1'b0;
            is_sc_o <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
            wstrb_o <= '0;
          end
        end
        // A failed SC means the reservation was lost: start over with a fresh LR.
        AMO_SCW: begin
          if (rdata_i == 32'd0) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
          end else begin
            state   <= ISSUE;
            re_o    <= 1'b1;
            is_lr_o <= 1'b1;
            addr_o  <= addr_q[DMEM_ADDRW+1:2];
          end
        end
`endif
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

  // The response follows rdata_i in the cycle after grant, so it is decoded combinationally.
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    case (state)
      ERR: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = 1'b1;
      end
      WAIT: begin
        if (!amo_q) begin
          rsp_valid_o = 1'b1;
          case (op_q)
            OP_LOAD:      rsp_rdata_o = load_data(rdata_i, size_q, addr_q[1:0], uns_q);
            OP_LR, OP_SC: rsp_rdata_o = rdata_i;
            default:      rsp_rdata_o = '0;
          endcase
        end
      end
`ifdef DBUS_LSU_AMO_EN
      AMO_SCW: begin
        if (rdata_i == 32'd0) begin
          rsp_valid_o = 1'b1;
          rsp_rdata_o = old_q;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_lsu.sv
// Directed bench for dbus_lsu: loads, stores, errors, LR/SC, AMO (when DBUS_LSU_AMO_EN) and async reset.
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 16
`endif

module tb_dbus_lsu;

  localparam int AW = `DMEM_ADDRW;

  logic          clk_i, rst_ni;
  logic          req_valid_i, req_ready_o, req_unsigned_i;
  logic [2:0]    req_op_i;
  logic [1:0]    req_size_i;
  logic [31:0]   req_addr_i, req_wdata_i;
  logic          rsp_valid_o, rsp_err_o;
  logic [31:0]   rsp_rdata_o;
  logic          re_o, we_o, is_lr_o, is_sc_o, stall_i;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o, rdata_i;
  logic [3:0]    wstrb_o;

  int checks   = 0;
  int failures = 0;

  dbus_lsu #(.DMEM_ADDRW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .is_lr_o(is_lr_o), .is_sc_o(is_sc_o), .rdata_i(rdata_i),
    .stall_i(stall_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for one edge; the DUT must be idle. Returns in the first cycle after acceptance.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i    = 1'b1;
    req_op_i       = op;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    tick();
    req_valid_i    = 1'b0;
  endtask

  task automatic runLoad(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    applyStimulus(3'b000, size, uns, addr, 32'h0);
    rdata_i = rd;
    checkOutput({tag, "_re"}, 32'(re_o), 32'd1);
    checkOutput({tag, "_addr"}, 32'(addr_o), exp_addr);
    checkOutput({tag, "_early_rsp"}, 32'(rsp_valid_o), 32'd0);
    tick();
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    checkOutput({tag, "_rdata"}, rsp_rdata_o, exp_data);
    checkOutput({tag, "_err"}, 32'(rsp_err_o), 32'd0);
    checkOutput({tag, "_re_drop"}, 32'(re_o), 32'd0);
    tick();
    checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    checkOutput({tag, "_rsp_once"}, 32'(rsp_valid_o), 32'd0);
  endtask

  task automatic runErr(input string tag, input logic [2:0] op, input logic [1:0] size,
                        input logic [31:0] addr);
    applyStimulus(op, size, 1'b0, addr, 32'hFFFF_FFFF);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    checkOutput({tag, "_err"}, 32'(rsp_err_o), 32'd1);
    checkOutput({tag, "_rdata"}, rsp_rdata_o, 32'd0);
    checkOutput({tag, "_nobus"}, {30'd0, re_o, we_o}, 32'd0);
    tick();
    checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    checkOutput({tag, "_rsp_once"}, 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_size_i = '0; req_unsigned_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; stall_i = 1'b0; rdata_i = '0;
    #12;
    checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst_bus", {28'd0, re_o, we_o, is_lr_o, is_sc_o}, 32'd0);
    checkOutput("rst_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'd0);
    checkOutput("rst_addr", 32'(addr_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    runLoad("lb_s_103", 2'b00, 1'b0, 32'h103, 32'h80FF1234, 32'h40, 32'hFFFFFF80);
    runLoad("lb_u_102", 2'b00, 1'b1, 32'h102, 32'h80FF1234, 32'h40, 32'h000000FF);
    runLoad("lb_s_101", 2'b00, 1'b0, 32'h101, 32'h80FF1234, 32'h40, 32'h00000012);
    runLoad("lh_s_102", 2'b01, 1'b0, 32'h102, 32'h80FF1234, 32'h40, 32'hFFFF80FF);
    runLoad("lh_u_100", 2'b01, 1'b1, 32'h100, 32'h80FF1234, 32'h40, 32'h00001234);
    runLoad("lw_104",   2'b10, 1'b0, 32'h104, 32'h80FF1234, 32'h41, 32'h80FF1234);

    // Store half with three stall cycles: bus request must hold for four cycles.
    stall_i = 1'b1;
    applyStimulus(3'b001, 2'b01, 1'b0, 32'h206, 32'h0000ABCD);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_i = 1'b0;
      checkOutput($sformatf("sh_we_%0d", i), 32'(we_o), 32'd1);
      checkOutput($sformatf("sh_strb_%0d", i), 32'(wstrb_o), 32'hC);
      checkOutput($sformatf("sh_wdata_%0d", i), wdata_o, 32'hABCDABCD);
      checkOutput($sformatf("sh_addr_%0d", i), 32'(addr_o), 32'h81);
      checkOutput($sformatf("sh_rsp_%0d", i), 32'(rsp_valid_o), 32'd0);
      tick();
    end
    checkOutput("sh_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("sh_rdata", rsp_rdata_o, 32'd0);
    checkOutput("sh_we_drop", {28'd0, we_o, 3'd0} | 32'(wstrb_o), 32'd0);
    tick();

    // Store byte at offset 1.
    applyStimulus(3'b001, 2'b00, 1'b0, 32'h0205, 32'h123456A5);
    checkOutput("sb_strb", 32'(wstrb_o), 32'h2);
    checkOutput("sb_wdata", wdata_o, 32'hA5A5A5A5);
    tick(); tick();

    runErr("lw_mis", 3'b000, 2'b10, 32'h101);
    runErr("lh_mis", 3'b000, 2'b01, 32'h103);
    runErr("rsv_size", 3'b000, 2'b11, 32'h100);
    runErr("lr_byte", 3'b010, 2'b00, 32'h100);
    runErr("rsv_op", 3'b110, 2'b10, 32'h100);

    // SC that fails.
    applyStimulus(3'b011, 2'b10, 1'b0, 32'h300, 32'hDEADBEEF);
    checkOutput("sc_bus", {28'd0, re_o, we_o, is_lr_o, is_sc_o}, 32'b0101);
    checkOutput("sc_wdata", wdata_o, 32'hDEADBEEF);
    checkOutput("sc_strb", 32'(wstrb_o), 32'hF);
    rdata_i = 32'd1;
    tick();
    checkOutput("sc_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'b10);
    checkOutput("sc_rdata", rsp_rdata_o, 32'd1);
    tick();

    // LR.
    applyStimulus(3'b010, 2'b10, 1'b0, 32'h304, 32'h0);
    checkOutput("lr_bus", {28'd0, re_o, we_o, is_lr_o, is_sc_o}, 32'b1010);
    rdata_i = 32'h55AA00FF;
    tick();
    checkOutput("lr_rdata", rsp_rdata_o, 32'h55AA00FF);
    tick();

`ifdef DBUS_LSU_AMO_EN
    // AMOADD of 3 onto 5; first SC fails, second succeeds.
    applyStimulus(3'b101, 2'b10, 1'b0, 32'h400, 32'd3);
    checkOutput("amo_lr1", {28'd0, re_o, we_o, is_lr_o, is_sc_o}, 32'b1010);
    checkOutput("amo_addr", 32'(addr_o), 32'h100);
    rdata_i = 32'd5;
    tick();
    checkOutput("amo_wait1_rsp", 32'(rsp_valid_o), 32'd0);
    tick();
    checkOutput("amo_sc1", {28'd0, re_o, we_o, is_lr_o, is_sc_o}, 32'b0101);
    checkOutput("amo_sc1_wdata", wdata_o, 32'd8);
    checkOutput("amo_sc1_strb", 32'(wstrb_o), 32'hF);
    rdata_i = 32'd1;
    tick();
    checkOutput("amo_scw1_rsp", 32'(rsp_valid_o), 32'd0);
    tick();
    checkOutput("amo_lr2", {28'd0, re_o, we_o, is_lr_o, is_sc_o}, 32'b1010);
    rdata_i = 32'd5;
    tick();
    tick();
    checkOutput("amo_sc2_wdata", wdata_o, 32'd8);
    rdata_i = 32'd0;
    tick();
    checkOutput("amo_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'b10);
    checkOutput("amo_old", rsp_rdata_o, 32'd5);
    tick();
    checkOutput("amo_ready", 32'(req_ready_o), 32'd1);
`else
    runErr("amo_off", 3'b101, 2'b10, 32'h400);
`endif

    // Reset while a stalled load is on the bus.
    stall_i = 1'b1;
    applyStimulus(3'b000, 2'b10, 1'b0, 32'h500, 32'h0);
    tick();
    checkOutput("rstmid_re_before", 32'(re_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("rstmid_re", 32'(re_o), 32'd0);
    checkOutput("rstmid_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rstmid_rsp", 32'(rsp_valid_o), 32'd0);
    stall_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    checkOutput("rstmid_after_rsp", 32'(rsp_valid_o), 32'd0);
    checkOutput("rstmid_after_ready", 32'(req_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
